// File: rtl/ahb_manager_dma_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ahb_manager_pack
// Description : Shared types for the AHB manager and its DMA sequencer:
//               transfer size encoding and the sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_manager_pack;

    // HSIZE encoding as presented on the manager user interface.
    typedef enum logic [2:0] {
        W8    = 3'd0,
        W16   = 3'd1,
        W32   = 3'd2,
        W64   = 3'd3,
        W128  = 3'd4,
        W256  = 3'd5,
        W512  = 3'd6,
        W1024 = 3'd7
    } t_hsize;

    // Sequencer states; explicit width keeps the encoding stable across tools.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        STREAM = 3'd2,
        WEND   = 3'd3,
        RDRAIN = 3'd4
    } t_dma_seq_state;

    localparam int ADDR_WDT = 32;

endpackage
`default_nettype wire

// File: rtl/ahb_dma_rd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ahb_dma_rd_fifo
// Description : Synchronous FIFO for read-return beats. Pop is honoured only
//               when non-empty; push is honoured when not full or when a pop
//               frees a slot in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_dma_rd_fifo #(
    parameter int WDT   = 64,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WDT-1:0]           i_data,
    input  logic                     i_pop,
    output logic [WDT-1:0]           o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WDT-1:0]   mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (count_q == CNT_W'(DEPTH));
    assign o_empty   = (count_q == '0);
    assign o_count   = count_q;
    assign o_data    = mem_q[rd_ptr_q];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Next pointer/occupancy; DEPTH is a power of two so pointers wrap freely.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards any buffered beats.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahb_manager_dma_seq.sv
`default_nettype none
// ============================================================================
// Module      : ahb_manager_dma_seq
// Description : Descriptor-driven sequencer feeding the AHB manager user
//               interface. Streams write beats from a valid/ready source and
//               issues read beats against read-FIFO credit, buffering the
//               returned data/address pairs for a valid/ready consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_manager_dma_seq
    import ahb_manager_pack::*;
#(
    parameter int DATA_WDT      = 32,
    parameter int BEAT_WDT      = 32,
    parameter int RD_FIFO_DEPTH = 8
) (
    input  logic                i_hclk,
    input  logic                i_hreset,
    // command
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic [31:0]         i_cmd_addr,
    input  logic [BEAT_WDT-1:0] i_cmd_len,
    input  logic                i_cmd_wr,
    input  t_hsize              i_cmd_size,
    // write stream
    input  logic                i_wdata_valid,
    output logic                o_wdata_ready,
    input  logic [DATA_WDT-1:0] i_wdata,
    // read stream
    output logic                o_rdata_valid,
    input  logic                i_rdata_ready,
    output logic [DATA_WDT-1:0] o_rdata,
    output logic [31:0]         o_raddr,
    // manager user interface
    output logic [31:0]         o_mgr_addr,
    output t_hsize              o_mgr_size,
    output logic [BEAT_WDT-1:0] o_mgr_min_len,
    output logic                o_mgr_wr,
    output logic                o_mgr_rd,
    output logic                o_mgr_first_xfer,
    output logic                o_mgr_idle,
    output logic [DATA_WDT-1:0] o_mgr_data,
    output logic                o_mgr_dav,
    input  logic                i_mgr_next,
    input  logic [DATA_WDT-1:0] i_mgr_data,
    input  logic [31:0]         i_mgr_addr,
    input  logic                i_mgr_dav,
    // status
    output logic                o_busy,
    output logic                o_done
);
    localparam int CNT_WDT = $clog2(RD_FIFO_DEPTH) + 1;
    localparam int ENT_WDT = DATA_WDT + ADDR_WDT;

    t_dma_seq_state      state_q, state_d;
    logic [BEAT_WDT-1:0] len_q, len_d;
    logic [BEAT_WDT-1:0] issued_q, issued_d;
    logic [BEAT_WDT-1:0] received_q, received_d;
    logic                is_wr_q, is_wr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [31:0]         mgr_addr_q, mgr_addr_d;
    t_hsize              mgr_size_q, mgr_size_d;
    logic [BEAT_WDT-1:0] mgr_min_len_q, mgr_min_len_d;
    logic                mgr_wr_q, mgr_wr_d;
    logic                mgr_rd_q, mgr_rd_d;
    logic                mgr_first_q, mgr_first_d;
    logic                mgr_idle_q, mgr_idle_d;
    logic [DATA_WDT-1:0] mgr_data_q, mgr_data_d;
    logic                mgr_dav_q, mgr_dav_d;

    logic                w_rd_active;
    logic                w_fifo_push;
    logic                w_fifo_pop;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [CNT_WDT-1:0]  w_fifo_count;
    logic [ENT_WDT-1:0]  w_fifo_rdata;
    logic [BEAT_WDT:0]   w_used;
    logic                w_credit_ok;

    // A read command accepts returns from its first issue until completion.
    assign w_rd_active = ~is_wr_q & ((state_q == STREAM) | (state_q == RDRAIN));
    assign w_fifo_push = w_rd_active & i_mgr_dav;
    assign w_fifo_pop  = ~w_fifo_empty & i_rdata_ready;

    // Slots already spoken for: buffered beats plus beats issued but not back.
    assign w_used      = {{(BEAT_WDT + 1 - CNT_WDT){1'b0}}, w_fifo_count}
                       + {1'b0, issued_q - received_q};
    assign w_credit_ok = ~w_fifo_full & (w_used < (BEAT_WDT + 1)'(RD_FIFO_DEPTH));

    assign o_cmd_ready   = (state_q == IDLE) & ~i_hreset;
    assign o_wdata_ready = is_wr_q & i_mgr_next &
                           ((state_q == ARM) |
                            ((state_q == STREAM) & (issued_q < len_q)));
    assign o_rdata_valid = ~w_fifo_empty;
    assign {o_rdata, o_raddr} = w_fifo_rdata;

    assign o_mgr_addr       = mgr_addr_q;
    assign o_mgr_size       = mgr_size_q;
    assign o_mgr_min_len    = mgr_min_len_q;
    assign o_mgr_wr         = mgr_wr_q;
    assign o_mgr_rd         = mgr_rd_q;
    assign o_mgr_first_xfer = mgr_first_q;
    assign o_mgr_idle       = mgr_idle_q;
    assign o_mgr_data       = mgr_data_q;
    assign o_mgr_dav        = mgr_dav_q;
    assign o_busy           = busy_q;
    assign o_done           = done_q;

    // Sequencer next-state; UI fields only change on edges where next=1.
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        issued_d      = issued_q;
        received_d    = received_q;
        is_wr_d       = is_wr_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        mgr_addr_d    = mgr_addr_q;
        mgr_size_d    = mgr_size_q;
        mgr_min_len_d = mgr_min_len_q;
        mgr_wr_d      = mgr_wr_q;
        mgr_rd_d      = mgr_rd_q;
        mgr_first_d   = mgr_first_q;
        mgr_idle_d    = mgr_idle_q;
        mgr_data_d    = mgr_data_q;
        mgr_dav_d     = mgr_dav_q;

        if (w_fifo_push) begin
            received_d = received_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    len_d         = i_cmd_len;
                    is_wr_d       = i_cmd_wr;
                    issued_d      = '0;
                    received_d    = '0;
                    mgr_addr_d    = i_cmd_addr;
                    mgr_size_d    = i_cmd_size;
                    mgr_min_len_d = i_cmd_len;
                    if (i_cmd_len == '0) begin
                        // Empty descriptor: report completion, touch no bus.
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = ARM;
                    end
                end
            end

            ARM: begin
                if (i_mgr_next) begin
                    if (is_wr_q) begin
                        // First write UI is only presented with real data.
                        if (i_wdata_valid) begin
                            mgr_first_d = 1'b1;
                            mgr_wr_d    = 1'b1;
                            mgr_idle_d  = 1'b0;
                            mgr_dav_d   = 1'b1;
                            mgr_data_d  = i_wdata;
                            issued_d    = {{(BEAT_WDT - 1){1'b0}}, 1'b1};
                            state_d     = STREAM;
                        end
                    end else if (w_credit_ok) begin
                        mgr_first_d = 1'b1;
                        mgr_rd_d    = 1'b1;
                        mgr_idle_d  = 1'b0;
                        issued_d    = {{(BEAT_WDT - 1){1'b0}}, 1'b1};
                        state_d     = STREAM;
                    end
                end
            end

            STREAM: begin
                if (i_mgr_next) begin
                    mgr_first_d = 1'b0;
                    if (issued_q == len_q) begin
                        // Last beat consumed on this edge: park the UI.
                        mgr_wr_d   = 1'b0;
                        mgr_rd_d   = 1'b0;
                        mgr_idle_d = 1'b1;
                        mgr_dav_d  = 1'b0;
                        state_d    = is_wr_q ? WEND : RDRAIN;
                    end else if (is_wr_q) begin
                        // A missing source beat becomes a dav=0 bubble.
                        mgr_dav_d  = i_wdata_valid;
                        mgr_data_d = i_wdata;
                        if (i_wdata_valid) begin
                            issued_d = issued_q + 1'b1;
                        end
                    end else begin
                        // No credit: present rd=0 until the consumer frees a slot.
                        mgr_rd_d = w_credit_ok;
                        if (w_credit_ok) begin
                            issued_d = issued_q + 1'b1;
                        end
                    end
                end
            end

            WEND: begin
                if (i_mgr_next) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            RDRAIN: begin
                // Completion waits for the last return push, not for the consumer.
                if (received_q == len_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer and UI registers; reset aborts any command in flight.
    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            state_q       <= IDLE;
            len_q         <= '0;
            issued_q      <= '0;
            received_q    <= '0;
            is_wr_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            mgr_addr_q    <= '0;
            mgr_size_q    <= W8;
            mgr_min_len_q <= '0;
            mgr_wr_q      <= 1'b0;
            mgr_rd_q      <= 1'b0;
            mgr_first_q   <= 1'b0;
            mgr_idle_q    <= 1'b1;
            mgr_data_q    <= '0;
            mgr_dav_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            issued_q      <= issued_d;
            received_q    <= received_d;
            is_wr_q       <= is_wr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            mgr_addr_q    <= mgr_addr_d;
            mgr_size_q    <= mgr_size_d;
            mgr_min_len_q <= mgr_min_len_d;
            mgr_wr_q      <= mgr_wr_d;
            mgr_rd_q      <= mgr_rd_d;
            mgr_first_q   <= mgr_first_d;
            mgr_idle_q    <= mgr_idle_d;
            mgr_data_q    <= mgr_data_d;
            mgr_dav_q     <= mgr_dav_d;
        end
    end

    ahb_dma_rd_fifo #(
        .WDT   (ENT_WDT),
        .DEPTH (RD_FIFO_DEPTH)
    ) u_rd_fifo (
        .i_clk   (i_hclk),
        .i_rst   (i_hreset),
        .i_push  (w_fifo_push),
        .i_data  ({i_mgr_data, i_mgr_addr}),
        .i_pop   (w_fifo_pop),
        .o_data  (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_ahb_manager_dma_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_manager_dma_seq
// Description : Directed bench for the DMA sequencer with a small manager
//               model answering reads and a per-cycle output checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_manager_dma_seq;
    import ahb_manager_pack::*;

    localparam int DW    = 32;
    localparam int BW    = 32;
    localparam int DEPTH = 8;
    localparam int RLAT  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic [31:0]   i_cmd_addr;
    logic [BW-1:0] i_cmd_len;
    logic          i_cmd_wr;
    t_hsize        i_cmd_size;
    logic          i_wdata_valid;
    logic          o_wdata_ready;
    logic [DW-1:0] i_wdata;
    logic          o_rdata_valid;
    logic          i_rdata_ready;
    logic [DW-1:0] o_rdata;
    logic [31:0]   o_raddr;
    logic [31:0]   o_mgr_addr;
    t_hsize        o_mgr_size;
    logic [BW-1:0] o_mgr_min_len;
    logic          o_mgr_wr, o_mgr_rd, o_mgr_first_xfer, o_mgr_idle;
    logic [DW-1:0] o_mgr_data;
    logic          o_mgr_dav;
    logic          i_mgr_next;
    logic [DW-1:0] i_mgr_data;
    logic [31:0]   i_mgr_addr;
    logic          i_mgr_dav;
    logic          o_busy, o_done;

    ahb_manager_dma_seq #(
        .DATA_WDT(DW), .BEAT_WDT(BW), .RD_FIFO_DEPTH(DEPTH)
    ) dut (
        .i_hclk(clk), .i_hreset(rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
        .i_cmd_wr(i_cmd_wr), .i_cmd_size(i_cmd_size),
        .i_wdata_valid(i_wdata_valid), .o_wdata_ready(o_wdata_ready), .i_wdata(i_wdata),
        .o_rdata_valid(o_rdata_valid), .i_rdata_ready(i_rdata_ready),
        .o_rdata(o_rdata), .o_raddr(o_raddr),
        .o_mgr_addr(o_mgr_addr), .o_mgr_size(o_mgr_size), .o_mgr_min_len(o_mgr_min_len),
        .o_mgr_wr(o_mgr_wr), .o_mgr_rd(o_mgr_rd), .o_mgr_first_xfer(o_mgr_first_xfer),
        .o_mgr_idle(o_mgr_idle), .o_mgr_data(o_mgr_data), .o_mgr_dav(o_mgr_dav),
        .i_mgr_next(i_mgr_next), .i_mgr_data(i_mgr_data), .i_mgr_addr(i_mgr_addr),
        .i_mgr_dav(i_mgr_dav),
        .o_busy(o_busy), .o_done(o_done)
    );

    // free-running clock
    always #5 clk = ~clk;

    int cyc = 0;
    // cycle counter used for read-return latency
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    // stimulus modes and reference-model state
    bit          next_rand  = 1'b0;
    bit          valid_rand = 1'b0;
    bit          stray      = 1'b0;
    int          ready_mode = 1;     // 0 hold low, 1 always high, 2 random
    int          widx = 0;           // next value the write source offers
    int          wexp = 0;           // number of write beats seen consumed
    int          rd_k = 0;           // number of read beats seen consumed
    int          rd_ret = 0;         // number of read returns driven
    int          ridx = 0;           // number of read beats popped
    int          done_cnt = 0;
    logic [31:0] cur_base = '0;
    int          cur_bytes = 1;
    int          cur_len = 0;
    bit          cur_wr = 1'b0;

    typedef struct { int k; int due; } rd_t;
    rd_t rq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset(input string p);
        chk({p, "_idle"},     64'(o_mgr_idle), 1);
        chk({p, "_wr"},       64'(o_mgr_wr), 0);
        chk({p, "_rd"},       64'(o_mgr_rd), 0);
        chk({p, "_first"},    64'(o_mgr_first_xfer), 0);
        chk({p, "_dav"},      64'(o_mgr_dav), 0);
        chk({p, "_data"},     64'(o_mgr_data), 0);
        chk({p, "_addr"},     64'(o_mgr_addr), 0);
        chk({p, "_size"},     64'(o_mgr_size), 0);
        chk({p, "_minlen"},   64'(o_mgr_min_len), 0);
        chk({p, "_cmdrdy"},   64'(o_cmd_ready), 0);
        chk({p, "_busy"},     64'(o_busy), 0);
        chk({p, "_done"},     64'(o_done), 0);
        chk({p, "_rvalid"},   64'(o_rdata_valid), 0);
        chk({p, "_wready"},   64'(o_wdata_ready), 0);
    endtask

    task automatic send_cmd(input logic [31:0] a, input int len, input bit wr, input t_hsize sz);
        int t;
        @(negedge clk);
        widx = 0; wexp = 0; rd_k = 0; rd_ret = 0; ridx = 0;
        cur_base = a; cur_bytes = 1 << int'(sz); cur_len = len; cur_wr = wr;
        i_cmd_addr = a; i_cmd_len = BW'(len); i_cmd_wr = wr; i_cmd_size = sz;
        i_cmd_valid = 1'b1;
        #1;
        t = 0;
        while (!o_cmd_ready && t < 100) begin
            @(negedge clk); #1; t++;
        end
        chk("cmd_accept_timeout", 64'(t < 100), 1);
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(negedge clk); #3; n++;
            if (o_done) break;
        end
    endtask

    // input driver and manager read-return model
    initial begin
        i_mgr_next = 1'b0; i_wdata_valid = 1'b0; i_wdata = '0; i_rdata_ready = 1'b0;
        i_mgr_dav = 1'b0; i_mgr_data = '0; i_mgr_addr = '0;
        forever begin
            @(negedge clk);
            i_mgr_next    = next_rand  ? ($urandom_range(0, 3) != 0) : 1'b1;
            i_wdata_valid = valid_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            i_wdata       = DW'(widx);
            i_rdata_ready = (ready_mode == 0) ? 1'b0 :
                            (ready_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            if (rst) rq.delete();
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                i_mgr_dav  = 1'b1;
                i_mgr_data = 32'hC0DE_0000 + 32'(rq[0].k);
                i_mgr_addr = cur_base + 32'(rq[0].k * cur_bytes);
                rd_ret++;
                void'(rq.pop_front());
            end else if (stray && $urandom_range(0, 1) == 1) begin
                i_mgr_dav  = 1'b1;
                i_mgr_data = 32'hDEAD_BEEF;
                i_mgr_addr = 32'hFFFF_FFF0;
            end else begin
                i_mgr_dav  = 1'b0;
            end
        end
    end

    // per-cycle compare against the behavioural model
    initial begin
        logic [DW+4:0] ui, snap;
        bit            pn, snap_ok, pdone;
        snap_ok = 1'b0; pdone = 1'b0; pn = 1'b1; snap = '0;
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                snap_ok = 1'b0;
                pdone   = 1'b0;
            end else begin
                ui = {o_mgr_wr, o_mgr_rd, o_mgr_first_xfer, o_mgr_idle, o_mgr_dav, o_mgr_data};
                if (snap_ok && !pn) chk("ui_hold_on_stall", 64'(ui), 64'(snap));
                if (i_mgr_next && o_mgr_wr && o_mgr_dav) begin
                    chk("write_beat_data", 64'(o_mgr_data), 64'(wexp));
                    wexp++;
                end
                if (i_mgr_next && o_mgr_rd) begin
                    rq.push_back('{k: rd_k, due: cyc + RLAT});
                    rd_k++;
                    chk("read_credit_bound", 64'((rd_k - ridx) <= DEPTH), 1);
                end
                if (i_wdata_valid && o_wdata_ready) widx++;
                if (o_rdata_valid && i_rdata_ready) begin
                    chk("rdata_order", 64'(o_rdata), 64'(32'hC0DE_0000 + 32'(ridx)));
                    chk("raddr_order", 64'(o_raddr), 64'(cur_base + 32'(ridx * cur_bytes)));
                    ridx++;
                end
                if (o_done) begin
                    done_cnt++;
                    chk("done_single_pulse", 64'(pdone), 0);
                    if (!cur_wr) chk("done_after_last_push", 64'(rd_ret), 64'(cur_len));
                end
                pdone   = o_done;
                snap    = ui;
                pn      = i_mgr_next;
                snap_ok = 1'b1;
            end
        end
    end

    // watchdog: abort if the flow ever stalls beyond every bounded wait
    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

    // directed test sequence
    initial begin
        int n, t, dc;
        i_cmd_valid = 1'b0; i_cmd_addr = '0; i_cmd_len = '0; i_cmd_wr = 1'b0; i_cmd_size = W8;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        check_reset("reset");
        @(negedge clk);
        rst = 1'b0;

        // T1: write 4 beats, source and manager always ready
        send_cmd(32'h10, 4, 1'b1, W8);
        t = 0;
        while (!o_mgr_wr && t < 50) begin @(negedge clk); #3; t++; end
        chk("t1_first_xfer", 64'(o_mgr_first_xfer), 1);
        chk("t1_first_dav",  64'(o_mgr_dav), 1);
        chk("t1_first_data", 64'(o_mgr_data), 0);
        chk("t1_addr",       64'(o_mgr_addr), 64'h10);
        chk("t1_min_len",    64'(o_mgr_min_len), 4);
        chk("t1_busy",       64'(o_busy), 1);
        wait_done(100, n);
        chk("t1_done_latency", 64'(n), 5);
        chk("t1_idle_at_done", 64'(o_mgr_idle), 1);
        @(negedge clk); #3;
        chk("t1_busy_after", 64'(o_busy), 0);
        chk("t1_done_low",   64'(o_done), 0);
        chk("t1_beats",      64'(wexp), 4);

        // T2: 42 beats with random source valid and manager stalls, stray returns
        next_rand = 1'b1; valid_rand = 1'b1; stray = 1'b1;
        send_cmd(32'h2000, 42, 1'b1, W32);
        wait_done(3000, n);
        chk("t2_done_seen", 64'(n < 3000), 1);
        chk("t2_beats",     64'(wexp), 42);
        stray = 1'b0; next_rand = 1'b0; valid_rand = 1'b0;
        @(negedge clk); #3;
        chk("t2_stray_not_pushed", 64'(o_rdata_valid), 0);

        // T3: read 20 beats with consumer blocked for 50 cycles
        ready_mode = 0;
        send_cmd(32'h1000, 20, 1'b0, W32);
        repeat (50) @(negedge clk);
        #3;
        chk("t3_issued_before_pop", 64'(rd_k), DEPTH);
        chk("t3_fifo_full_valid",   64'(o_rdata_valid), 1);
        chk("t3_no_done_yet",       64'(o_busy), 1);
        ready_mode = 2; next_rand = 1'b1;
        wait_done(3000, n);
        chk("t3_done_seen", 64'(n < 3000), 1);
        t = 0;
        while (o_rdata_valid && t < 300) begin @(negedge clk); #3; t++; end
        chk("t3_delivered", 64'(ridx), 20);
        chk("t3_issued",    64'(rd_k), 20);
        next_rand = 1'b0; ready_mode = 1;

        // T4: zero-length command
        dc = done_cnt;
        send_cmd(32'h40, 0, 1'b1, W8);
        @(negedge clk); #3;
        chk("t4_done_next_cycle", 64'(o_done), 1);
        chk("t4_idle",   64'(o_mgr_idle), 1);
        chk("t4_no_wr",  64'(o_mgr_wr), 0);
        chk("t4_no_rd",  64'(o_mgr_rd), 0);
        @(negedge clk); #3;
        chk("t4_done_once", 64'(done_cnt - dc), 1);
        chk("t4_still_idle", 64'({o_mgr_idle, o_mgr_wr, o_mgr_rd}), 64'b100);

        // T5: reset in the middle of a 16-beat read
        ready_mode = 0;
        send_cmd(32'h3000, 16, 1'b0, W16);
        t = 0;
        while (rd_k < 5 && t < 100) begin @(negedge clk); #3; t++; end
        chk("t5_reached_5", 64'(rd_k), 5);
        dc = done_cnt;
        rst = 1'b1;
        #1;
        check_reset("t5_async");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        chk("t5_no_done", 64'(done_cnt - dc), 0);
        chk("t5_fifo_flushed", 64'(o_rdata_valid), 0);
        ready_mode = 1;
        send_cmd(32'h50, 2, 1'b1, W8);
        wait_done(100, n);
        chk("t5_write_done", 64'(n < 100), 1);
        chk("t5_write_beats", 64'(wexp), 2);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
